// File: rtl/fft_pkg.sv
// Shared FFT pipeline helpers: default sample width, read FSM states,
// compile-time log2 and a width-parameterised bit reversal.
package fft_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int MAX_LOG_N = 12;

    typedef enum logic {IDLE, READ} rd_state_t;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int b = 0; b < 31; b++)
            if ((1 << b) < n) r = b + 1;
        return r;
    endfunction

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_LOG_N-1:0] bitrev(input logic [MAX_LOG_N-1:0] v, input int w);
        logic [MAX_LOG_N-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_LOG_N; b++)
            if (b < w) r[w-1-b] = v[b];
        return r;
    endfunction
endpackage

// File: rtl/bitrev_ram.sv
// Simple dual-port frame memory: synchronous write, registered read, one clock.
// The address MSB selects the ping-pong bank.
module bitrev_ram #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/bitrev_reorder.sv
// Restores natural bin order after the SDF chain using a ping-pong frame buffer.
// Define BITREV_OINDEX_EN to add the oindex output (natural bin of each sample).
module bitrev_reorder import fft_pkg::*; #(
    parameter  int N     = 64,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int LOG_N = log2(N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idata_en,
    input  logic [WIDTH-1:0] idata_r,
    input  logic [WIDTH-1:0] idata_i,
    output logic             odata_en,
    output logic [WIDTH-1:0] odata_r,
    output logic [WIDTH-1:0] odata_i,
    output logic             drop
`ifdef BITREV_OINDEX_EN
   ,output logic [LOG_N-1:0] oindex
`endif
);
    localparam int STAGES = 1;

    logic [LOG_N-1:0]   wcnt, wrev, rcnt, rcnt_nx;
    logic               wbank, rbank, rbank_nx;
    logic               commit, rd_issue;
    rd_state_t          state, state_nx;
    logic [STAGES:0]    vld_pipe;
    logic [2*WIDTH-1:0] rdata;

    // Write side: scatter to bit-reversed addresses, commit on the Nth sample.
    assign commit = idata_en && (wcnt == LOG_N'(N - 1));
    assign wrev   = LOG_N'(bitrev(MAX_LOG_N'(wcnt), LOG_N));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wcnt  <= '0;
            wbank <= 1'b0;
            drop  <= 1'b0;
        end else begin
            drop <= 1'b0;
            if (idata_en) begin
                wcnt <= wcnt + LOG_N'(1);
                if (commit) wbank <= ~wbank;
            end else if (wcnt != '0) begin
                wcnt <= '0;
                drop <= 1'b1;
            end
        end
    end

    // Read FSM: a commit landing on the last read chains straight into the other bank.
    always_comb begin
        state_nx = state;
        rcnt_nx  = rcnt;
        rbank_nx = rbank;
        case (state)
            IDLE: if (commit) begin
                state_nx = READ;
                rcnt_nx  = '0;
                rbank_nx = wbank;
            end
            READ: begin
                rcnt_nx = rcnt + LOG_N'(1);
                if (rcnt == LOG_N'(N - 1)) begin
                    if (commit) rbank_nx = ~rbank;
                    else        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rcnt  <= '0;
            rbank <= 1'b0;
        end else begin
            state <= state_nx;
            rcnt  <= rcnt_nx;
            rbank <= rbank_nx;
        end
    end

    assign rd_issue = (state == READ);

    bitrev_ram #(.AW(LOG_N + 1), .DW(2 * WIDTH)) u_ram (
        .clock (clock),
        .we    (idata_en),
        .waddr ({wbank, wrev}),
        .wdata ({idata_r, idata_i}),
        .re    (rd_issue),
        .raddr ({rbank, rcnt}),
        .rdata (rdata)
    );

    // vld_pipe[0]: RAM output valid, vld_pipe[STAGES]: output register valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            odata_r  <= '0;
            odata_i  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], rd_issue};
            if (vld_pipe[0]) {odata_r, odata_i} <= rdata;
            else             {odata_r, odata_i} <= '0;
        end
    end

    assign odata_en = vld_pipe[STAGES];

`ifdef BITREV_OINDEX_EN
    logic [LOG_N-1:0] ridx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ridx   <= '0;
            oindex <= '0;
        end else begin
            ridx   <= rcnt;
            oindex <= vld_pipe[0] ? ridx : '0;
        end
    end
`endif
endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed bench for bitrev_reorder: ordering, latency, streaming, drop, reset, N=16.
module tb_bitrev_reorder;
    localparam int N  = 64;
    localparam int N2 = 16;
    localparam int W  = 16;
    localparam int P  = 10;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         idata_en = 1'b0;
    logic [W-1:0] idata_r = '0, idata_i = '0;
    logic         odata_en, drop;
    logic [W-1:0] odata_r, odata_i;
    logic         s_en = 1'b0;
    logic [W-1:0] s_r = '0, s_i = '0;
    logic         s_oen, s_drop;
    logic [W-1:0] s_or, s_oi;
`ifdef BITREV_OINDEX_EN
    logic [5:0]   oindex;
    logic [3:0]   s_oindex;
`endif

    int  nvec = 0, nerr = 0;
    int  q_r[$], q_i[$], q_ix[$], s_q[$], s_ix[$];
    time q_t[$];
    time last_t = 0;
    int  drop_cnt = 0, s_drop_cnt = 0, zero_bad = 0;

    always #(P/2) clock = ~clock;

    bitrev_reorder #(.N(N), .WIDTH(W)) dut (
        .clock(clock), .reset(reset), .idata_en(idata_en), .idata_r(idata_r), .idata_i(idata_i),
        .odata_en(odata_en), .odata_r(odata_r), .odata_i(odata_i), .drop(drop)
`ifdef BITREV_OINDEX_EN
       ,.oindex(oindex)
`endif
    );

    bitrev_reorder #(.N(N2), .WIDTH(W)) dut16 (
        .clock(clock), .reset(reset), .idata_en(s_en), .idata_r(s_r), .idata_i(s_i),
        .odata_en(s_oen), .odata_r(s_or), .odata_i(s_oi), .drop(s_drop)
`ifdef BITREV_OINDEX_EN
       ,.oindex(s_oindex)
`endif
    );

    // Output collector, sampling half a cycle away from the active edge.
    always @(negedge clock) begin
        if (odata_en) begin
            q_r.push_back(int'(odata_r));
            q_i.push_back(int'($signed(odata_i)));
            q_t.push_back($time);
`ifdef BITREV_OINDEX_EN
            q_ix.push_back(int'(oindex));
`endif
        end else if (odata_r != '0 || odata_i != '0) zero_bad++;
        if (s_oen) begin
            s_q.push_back(int'(s_or));
`ifdef BITREV_OINDEX_EN
            s_ix.push_back(int'(s_oindex));
`endif
        end else if (s_or != '0 || s_oi != '0) zero_bad++;
`ifdef BITREV_OINDEX_EN
        if (!odata_en && oindex != '0) zero_bad++;
        if (!s_oen && s_oindex != '0) zero_bad++;
`endif
        if (drop) drop_cnt++;
        if (s_drop) s_drop_cnt++;
    end

    function automatic int rev(input int v, input int w);
        int r;
        r = 0;
        for (int b = 0; b < w; b++)
            if (v[b]) r = r | (1 << (w - 1 - b));
        return r;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear();
        q_r.delete(); q_i.delete(); q_t.delete(); q_ix.delete();
    endtask

    // Sample k carries r = base+k, i = -(base+k).
    task automatic drive(input int nsamp, input int base);
        for (int k = 0; k < nsamp; k++) begin
            @(negedge clock);
            idata_en = 1'b1;
            idata_r  = W'(base + k);
            idata_i  = W'(-(base + k));
            last_t   = $time;
        end
        @(negedge clock);
        idata_en = 1'b0; idata_r = '0; idata_i = '0;
    endtask

    task automatic check_frames(input string tag, input int nfr, input int base);
        int bad, e, j;
        bad = 0;
        chk({tag, "_count"}, q_r.size(), nfr * N);
        if (q_r.size() == nfr * N) begin
            chk({tag, "_contig"}, longint'((q_t[q_t.size()-1] - q_t[0]) / P) + 1, nfr * N);
            for (int f = 0; f < nfr; f++)
                for (int n = 0; n < N; n++) begin
                    j = f * N + n;
                    e = base + f * N + rev(n, 6);
                    if (q_r[j] != e || q_i[j] != -e) bad++;
`ifdef BITREV_OINDEX_EN
                    if (q_ix[j] != n) bad++;
`endif
                end
            chk({tag, "_data"}, bad, 0);
        end
    endtask

    initial begin
        int bad;
        repeat (3) @(negedge clock);
        chk("rst_en",   odata_en, 0);
        chk("rst_r",    odata_r,  0);
        chk("rst_i",    odata_i,  0);
        chk("rst_drop", drop,     0);
        reset = 1'b0;
        idle(2);

        // Ordering and latency, single frame r=k, i=-k.
        clear();
        drive(N, 0);
        idle(N + 8);
        chk("ord_out0",  q_r.size() > 0  ? q_r[0]  : -1, 0);
        chk("ord_out1",  q_r.size() > 1  ? q_r[1]  : -1, 32);
        chk("ord_out2",  q_r.size() > 2  ? q_r[2]  : -1, 16);
        chk("ord_out63", q_r.size() > 63 ? q_r[63] : -1, 63);
        chk("lat_first", q_t.size() > 0 ? longint'(q_t[0] - last_t) : -1, 3 * P);
        check_frames("ord", 1, 0);

        // Three frames back to back.
        clear();
        drive(3 * N, 1000);
        idle(N + 8);
        check_frames("stream", 3, 1000);

        // Partial frame discarded, then one full frame.
        clear();
        drop_cnt = 0;
        drive(40, 3000);
        idle(5);
        drive(N, 4000);
        idle(N + 8);
        chk("part_drop", drop_cnt, 1);
        check_frames("part", 1, 4000);

        // Reset in the middle of an output frame.
        clear();
        drive(N, 5000);
        for (int c = 0; c < 200; c++) begin
            @(posedge clock);
            #2;
            if (q_r.size() >= 20) break;
        end
        chk("rst_mid_reached", q_r.size() >= 20, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_en",   odata_en, 0);
        chk("rst_mid_r",    odata_r,  0);
        chk("rst_mid_i",    odata_i,  0);
        chk("rst_mid_drop", drop,     0);
        idle(2);
        reset = 1'b0;
        idle(2);
        clear();
        drive(N, 6000);
        idle(N + 8);
        check_frames("post_rst", 1, 6000);

        // N=16 instance: out[n] carries input bitrev4(n).
        for (int k = 0; k < N2; k++) begin
            @(negedge clock);
            s_en = 1'b1; s_r = W'(k); s_i = '0;
        end
        @(negedge clock);
        s_en = 1'b0; s_r = '0;
        idle(N2 + 8);
        chk("n16_count", s_q.size(), N2);
        chk("n16_out1", s_q.size() > 1 ? s_q[1] : -1, 8);
        bad = 0;
        if (s_q.size() == N2)
            for (int n = 0; n < N2; n++) begin
                if (s_q[n] != rev(n, 4)) bad++;
`ifdef BITREV_OINDEX_EN
                if (s_ix[n] != n) bad++;
`endif
            end
        chk("n16_data", bad, 0);
        chk("n16_drop", s_drop_cnt, 0);
        chk("zero_outside", zero_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
